// File: rtl/uart_defs.sv
// Shared UART definitions: receiver state encoding, interrupt flag layout and parity helper.
package uart_defs;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } RXState_t;

  typedef struct packed {
    logic overrun_error;
    logic framing_error;
    logic parity_error;
  } RXIrqFlags_t;

  // Returns 1 when data bits, received parity bit and the odd/even selector disagree.
  function automatic logic parity_mismatch(input logic [8:0] data, input logic par_bit,
                                           input logic odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// Word-level handshake between the UART receiver and the RX FIFO.
interface uart_rx_deser_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every divider+1 clocks, restartable.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divider,
  input  logic             restart,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_r;

  assign tick = (cnt_r == divider);

  // Free-running counter; reloads on tick or when a start edge realigns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (restart || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end
endmodule

// File: rtl/uart_rx_deser.sv
// Line-side UART receiver: oversampled start detection, LSB-first deserialisation,
// optional parity and sticky parity/framing/overrun flags.
module uart_rx_deser
  import uart_defs::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divider,
  input  logic             enable,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             flush,
  input  logic             rx_i,
  uart_rx_deser_if.master  out_if,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overrun_error,
  output logic             busy
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [1:0] ST_IDLE   = RX_IDLE;
  localparam logic [1:0] ST_SHIFT  = RX_SHIFT;
  localparam logic [1:0] ST_PARITY = RX_PARITY;
  localparam logic [1:0] ST_STOP   = RX_STOP;
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  logic              rx_meta_r, rxs_r, rxs_d_r;
  logic [1:0]        state_r, state_s;
  logic              pend_r, pend_s;
  logic [BCW-1:0]    bit_r, bit_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              pe_r, pe_s;
  logic [OSW-1:0]    os_r, os_s;
  logic              tick_s, restart_s, half_s, centre_s, fall_s, fe_s, commit_s, accept_s;
  logic [8:0]        ext_s;
  logic              busy_r;
  RXIrqFlags_t       flags_r;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .divider (divider),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
      rxs_d_r   <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rxs_r     <= rx_meta_r;
      rxs_d_r   <= rxs_r;
    end
  end

  assign fall_s    = rxs_d_r & ~rxs_r;
  assign restart_s = enable & (state_r == ST_IDLE) & ~pend_r & fall_s;
  assign half_s    = tick_s & (os_r == OS_HALF);
  assign centre_s  = tick_s & (os_r == OS_LAST);
  assign fe_s      = ~rxs_r;
  assign accept_s  = out_if.out_valid & out_if.out_ready;

  // Oversample phase: restarts on the start edge, realigns to bit centres after the half-bit check.
  always_comb begin
    os_s = os_r;
    if (restart_s) begin
      os_s = '0;
    end else if (tick_s) begin
      if ((pend_r && (os_r == OS_HALF)) || (os_r == OS_LAST)) begin
        os_s = '0;
      end else begin
        os_s = os_r + OSW'(1);
      end
    end else begin
      os_s = os_r;
    end
  end

  // Frame sequencing; pend_r marks a start edge awaiting its mid-bit confirmation.
  always_comb begin
    state_s  = state_r;
    pend_s   = pend_r;
    bit_s    = bit_r;
    shift_s  = shift_r;
    pe_s     = pe_r;
    commit_s = 1'b0;
    ext_s    = '0;
    ext_s[DATA_W-1:0] = shift_r;
    if (!enable) begin
      state_s = ST_IDLE;
      pend_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pend_r) begin
            if (half_s) begin
              pend_s = 1'b0;
              if (!rxs_r) begin
                state_s = ST_SHIFT;
                bit_s   = '0;
                pe_s    = 1'b0;
              end else begin
                state_s = ST_IDLE;
              end
            end else begin
              pend_s = 1'b1;
            end
          end else if (restart_s) begin
            pend_s = 1'b1;
          end else begin
            pend_s = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (centre_s) begin
            shift_s = {rxs_r, shift_r[DATA_W-1:1]};
            bit_s   = bit_r + BCW'(1);
            if (bit_r == LAST_BIT) begin
              state_s = parity_en ? ST_PARITY : ST_STOP;
            end else begin
              state_s = ST_SHIFT;
            end
          end else begin
            state_s = ST_SHIFT;
          end
        end
        ST_PARITY: begin
          if (centre_s) begin
            pe_s    = parity_mismatch(ext_s, rxs_r, parity_odd);
            state_s = ST_STOP;
          end else begin
            state_s = ST_PARITY;
          end
        end
        ST_STOP: begin
          if (centre_s) begin
            commit_s = 1'b1;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_STOP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          pend_s  = 1'b0;
        end
      endcase
    end
  end

  // Frame state registers; busy also covers the start-bit confirmation window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pend_r  <= 1'b0;
      bit_r   <= '0;
      shift_r <= '0;
      pe_r    <= 1'b0;
      os_r    <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      pe_r    <= pe_s;
      os_r    <= os_s;
      busy_r  <= (state_s != ST_IDLE) | pend_s;
    end
  end

  // Output word and sticky flags; a commit coinciding with flush is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      flags_r          <= '0;
    end else if (flush) begin
      out_if.out_valid <= 1'b0;
      flags_r          <= '0;
    end else if (commit_s) begin
      if (!out_if.out_valid || accept_s) begin
        out_if.out_data       <= shift_r;
        out_if.out_valid      <= 1'b1;
        flags_r.parity_error  <= flags_r.parity_error | pe_r;
        flags_r.framing_error <= flags_r.framing_error | fe_s;
      end else begin
        flags_r.overrun_error <= 1'b1;
      end
    end else if (accept_s) begin
      out_if.out_valid <= 1'b0;
    end
  end

  assign parity_error  = flags_r.parity_error;
  assign framing_error = flags_r.framing_error;
  assign overrun_error = flags_r.overrun_error;
  assign busy          = busy_r;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: directed frames at 16 clk/bit, monitor checks accepted words.
module tb_uart_rx_deser;
  logic        clk = 1'b0;
  logic        rst, enable, parity_en, parity_odd, flush, rx_i;
  logic [15:0] divider;
  logic        parity_error, framing_error, overrun_error, busy;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat;
  logic [7:0]  exp_q[$];

  uart_rx_deser_if #(.DATA_W(8)) rx_if ();

  uart_rx_deser #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .divider       (divider),
    .enable        (enable),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .flush         (flush),
    .rx_i          (rx_i),
    .out_if        (rx_if),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && rx_if.out_valid && rx_if.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected no word", rx_if.out_data);
      end else begin
        check("word", {24'h0, rx_if.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                            input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    rx_i = 1'b1;
    repeat (32) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; flush = 1'b0;
    rx_i = 1'b1; divider = 16'd0; rx_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, rx_if.out_valid}, 32'd0);
    check("rst_out_data", {24'h0, rx_if.out_data}, 32'd0);
    check("rst_parity", {31'h0, parity_error}, 32'd0);
    check("rst_framing", {31'h0, framing_error}, 32'd0);
    check("rst_overrun", {31'h0, overrun_error}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);

    // Basic frame with latency window measured from the start edge.
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        while (!rx_if.out_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    n_tests++;
    if (lat < 150 || lat > 162) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d clk expected 150..162", lat);
    end
    check("basic_flags", {29'h0, overrun_error, framing_error, parity_error}, 32'd0);

    // Even parity.
    parity_en = 1'b1; parity_odd = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_good", {31'h0, parity_error}, 32'd0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check("par_bad", {31'h0, parity_error}, 32'd1);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    check("par_sticky", {31'h0, parity_error}, 32'd1);
    do_flush();
    check("par_flush", {31'h0, parity_error}, 32'd0);
    parity_en = 1'b0;

    // Framing error followed by resync on a clean frame.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("frm_err", {31'h0, framing_error}, 32'd1);
    check("frm_no_par", {31'h0, parity_error}, 32'd0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    check("frm_sticky", {31'h0, framing_error}, 32'd1);
    do_flush();
    check("frm_flush", {31'h0, framing_error}, 32'd0);

    // Start glitch shorter than half a bit.
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_i = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_busy_hi", {31'h0, busy}, 32'd1);
    repeat (16) @(posedge clk);
    #1;
    check("glitch_busy_lo", {31'h0, busy}, 32'd0);
    check("glitch_no_valid", {31'h0, rx_if.out_valid}, 32'd0);

    // Overrun: second word dropped while the first is held.
    rx_if.out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_data", {24'h0, rx_if.out_data}, 32'h11);
    check("ovr_flag", {31'h0, overrun_error}, 32'd1);
    check("ovr_valid", {31'h0, rx_if.out_valid}, 32'd1);
    rx_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_drained", {31'h0, rx_if.out_valid}, 32'd0);
    do_flush();
    check("ovr_flush", {31'h0, overrun_error}, 32'd0);

    // Reset mid-frame with a held word and a flag set.
    rx_if.out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("pre_rst_frm", {31'h0, framing_error}, 32'd1);
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        repeat (80) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'h0, rx_if.out_valid}, 32'd0);
        check("midrst_data", {24'h0, rx_if.out_data}, 32'd0);
        check("midrst_flags", {29'h0, overrun_error, framing_error, parity_error}, 32'd0);
        check("midrst_busy", {31'h0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    check("postrst_busy", {31'h0, busy}, 32'd0);
    rx_if.out_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check("postrst_flags", {29'h0, overrun_error, framing_error, parity_error}, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
